// File: rtl/ram_burst_master_pkg.sv
// Shared types and default widths for the RAM burst master.
// Imported by the interface, the read FIFO and the top.
package ram_ctrl_pkg;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 32;
  localparam int LW_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/ram_burst_master_if.sv
// Command, write-data, read-data and status channels of the burst master.
// master = burst master side, slave = client side.
interface ram_burst_master_if
  import ram_ctrl_pkg::*;
#(
  parameter int AWIDTH = AW_DEF,
  parameter int DWIDTH = DW_DEF,
  parameter int LWIDTH = LW_DEF
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [AWIDTH-1:0] cmd_addr;
  logic [LWIDTH-1:0] cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DWIDTH-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DWIDTH-1:0] rd_data;
  logic              busy;
  logic              done;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output busy, done
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  busy, done
  );

endinterface

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry read buffer absorbing RAM latency and downstream stalls.
// Push and pop may happen together, including when full.
module ram_rd_skid_fifo
  import ram_ctrl_pkg::*;
#(
  parameter int DWIDTH = DW_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DWIDTH-1:0] din,
  input  logic              pop,
  output logic [DWIDTH-1:0] dout,
  output logic [1:0]        count
);

  logic [DWIDTH-1:0] r_mem [2];
  logic              r_wp;
  logic              r_rp;
  logic [1:0]        r_count;
  logic              w_pop;
  logic              w_push;

  assign w_pop  = pop & (r_count != 2'd0);
  assign w_push = push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign dout  = r_mem[r_rp];
  assign count = r_count;

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port RAM with one-cycle read latency.
// Streams write beats straight to the RAM; reads go through a 2-deep buffer.
module ram_burst_master
  import ram_ctrl_pkg::*;
#(
  parameter int AWIDTH = AW_DEF,
  parameter int DWIDTH = DW_DEF,
  parameter int LWIDTH = LW_DEF
) (
  input  logic                clock,
  input  logic                reset,
  ram_burst_master_if.master  bus,
  output logic [AWIDTH-1:0]   ram_addr,
  output logic [DWIDTH-1:0]   ram_din,
  output logic                ram_we,
  input  logic [DWIDTH-1:0]   ram_dout
);

  localparam logic [LWIDTH:0] REM_ONE = 1;

  state_t            r_state;
  logic [AWIDTH-1:0] r_addr;
  logic [LWIDTH:0]   r_rem;
  logic              r_inflight;
  logic              r_done;
  logic [DWIDTH-1:0] r_din;

  logic [1:0]        w_cnt;
  logic [2:0]        w_occ;
  logic              w_pop;
  logic              w_issue;
  logic              w_wbeat;
  logic              w_drained;

  assign w_pop   = bus.rd_valid & bus.rd_ready;
  assign w_wbeat = (r_state == ST_WR) & bus.wr_valid;

  // Occupancy the buffer will have once this cycle's pop retires.
  assign w_occ = {1'b0, w_cnt} + {2'b00, r_inflight}
               - {2'b00, w_pop};

  assign w_issue = (r_state == ST_RD) & (r_rem != '0)
                 & (w_occ < 3'd2);

  assign w_drained = ~r_inflight
                   & ((w_cnt == 2'd0)
                   | ((w_cnt == 2'd1) & w_pop));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
      r_din      <= '0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_addr  <= bus.cmd_addr;
            r_rem   <= {1'b0, bus.cmd_len} + REM_ONE;
            r_state <= bus.cmd_we ? ST_WR : ST_RD;
          end
        end
        ST_WR: begin
          if (bus.wr_valid) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - REM_ONE;
            r_din  <= bus.wr_data;
            if (r_rem == REM_ONE) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (w_issue) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - REM_ONE;
            if (r_rem == REM_ONE) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ram_rd_skid_fifo #(
    .DWIDTH (DWIDTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (r_inflight),
    .din   (ram_dout),
    .pop   (w_pop),
    .dout  (bus.rd_data),
    .count (w_cnt)
  );

  // Gated by reset so the command port stays closed while held.
  assign bus.cmd_ready = (r_state == ST_IDLE) & ~reset;
  assign bus.wr_ready  = (r_state == ST_WR);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = r_done;
  assign bus.rd_valid  = (w_cnt != 2'd0);

  assign ram_addr = r_addr;
  assign ram_we   = w_wbeat;
  assign ram_din  = (r_state == ST_WR) ? bus.wr_data : r_din;

endmodule
